msi_tlp_gen: RTL and testbench

- Responder end of the cfg_interrupt/cfg_interrupt_rdy/cfg_interrupt_di handshake driven by the interrupt requester.
- Accepts one interrupt vector at a time and acknowledges it.
- Merges the vector into the host-programmed MSI message data.
- Emits the MSI as a 1-DW Memory Write TLP on the 64-bit TX stream, via a req/gnt arbiter port.

---
 rtl/msi_pkg.sv | 36 +++
 rtl/msi_tlp_fmt.sv | 59 +++++
 rtl/msi_tlp_gen.sv | 139 +++++++++++++
 tb/tb_msi_tlp_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// Shared types and constants for the MSI Memory Write TLP generator.
// Holds the FSM encoding, the capture snapshot and the vector-mask helper.
package msi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_REQ,
        S_BEAT0,
        S_BEAT1,
        S_BEAT2,
        S_DONE
    } state_t;

    localparam logic [2:0] FMT_MWR32 = 3'b010;
    localparam logic [2:0] FMT_MWR64 = 3'b011;
    localparam logic [4:0] TYPE_MEM  = 5'b00000;
    localparam logic [2:0] MAX_MME   = 3'd5;

    typedef struct packed {
        logic        en;
        logic [7:0]  di;
        logic [2:0]  mme;
        logic [63:0] addr;
        logic [15:0] data;
        logic [15:0] cid;
    } snap_t;

    // Low bits of the message data that the vector number may replace.
    function automatic logic [7:0] vec_mask(input logic [2:0] mme);
        logic [2:0] m;
        m = (mme > MAX_MME) ? MAX_MME : mme;
        return 8'((9'd1 << m) - 9'd1);
    endfunction

endpackage

// File: rtl/msi_tlp_fmt.sv
// Combinational builder for the MSI MWr TLP: header DWs, payload,
// and the per-beat data/keep/last for the 64-bit stream.
module msi_tlp_fmt
    import msi_pkg::*;
#(
    parameter logic [7:0] REQ_TAG = 8'h00
) (
    input  snap_t       i_snap,
    input  logic [1:0]  i_beat,
    output logic [63:0] o_data,
    output logic [7:0]  o_keep,
    output logic        o_last,
    output logic        o_trunc
);

    logic [7:0]  w_mask;
    logic [15:0] w_msg;
    logic        w_is64;
    logic [2:0]  w_fmt;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_pd;
    logic [31:0] w_alo;
    logic [31:0] w_ahi;

    assign w_mask  = vec_mask(i_snap.mme);
    assign w_msg   = (i_snap.data & ~{8'h00, w_mask})
                   | {8'h00, i_snap.di & w_mask};
    assign o_trunc = i_snap.di > w_mask;

    assign w_is64 = |i_snap.addr[63:32];
    assign w_fmt  = w_is64 ? FMT_MWR64 : FMT_MWR32;
    assign w_dw0  = {w_fmt, TYPE_MEM, 1'b0, 3'b000, 4'h0,
                     1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
    assign w_dw1  = {i_snap.cid, REQ_TAG, 4'h0, 4'hF};
    // Payload byte 0 travels in the most significant byte of the DW.
    assign w_pd   = {w_msg[7:0], w_msg[15:8], 16'h0000};
    assign w_alo  = {i_snap.addr[31:2], 2'b00};
    assign w_ahi  = i_snap.addr[63:32];

    always_comb begin
        o_data = {w_dw1, w_dw0};
        o_keep = 8'hFF;
        o_last = 1'b0;
        unique case (i_beat)
            2'd1: begin
                o_data = w_is64 ? {w_alo, w_ahi} : {w_pd, w_alo};
                o_last = !w_is64;
            end
            2'd2: begin
                o_data = {32'h0000_0000, w_pd};
                o_keep = 8'h0F;
                o_last = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/msi_tlp_gen.sv
// MSI responder: acks cfg_interrupt requests, merges the vector into
// the MSI data and sends a 1-DW MWr on the arbitrated 64-bit TX stream.
module msi_tlp_gen
    import msi_pkg::*;
#(
    parameter logic [7:0]  REQ_TAG = 8'h00,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             user_clk,
    input  logic             reset_n,
    input  logic             cfg_interrupt,
    input  logic [7:0]       cfg_interrupt_di,
    output logic             cfg_interrupt_rdy,
    input  logic             cfg_msi_enable,
    input  logic [2:0]       cfg_mmenable,
    input  logic [63:0]      cfg_msi_addr,
    input  logic [15:0]      cfg_msi_data,
    input  logic [15:0]      cfg_completer_id,
    output logic             tx_req,
    input  logic             tx_gnt,
    output logic [63:0]      tx_data,
    output logic [7:0]       tx_keep,
    output logic             tx_valid,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic             busy,
    output logic             msi_dropped,
    output logic             vec_trunc,
    output logic [CNT_W-1:0] msi_sent_cnt
);

    state_t           r_state;
    state_t           w_next;
    snap_t            r_snap;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_beat;
    logic [63:0]      w_data;
    logic [7:0]       w_keep;
    logic             w_last;
    logic             w_trunc;
    logic             w_capture;

    assign w_capture = (r_state == S_IDLE) && cfg_interrupt && r_armed;

    msi_tlp_fmt #(
        .REQ_TAG (REQ_TAG)
    ) u_fmt (
        .i_snap  (r_snap),
        .i_beat  (w_beat),
        .o_data  (w_data),
        .o_keep  (w_keep),
        .o_last  (w_last),
        .o_trunc (w_trunc)
    );

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b1;
            r_snap  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // A level still held from the acked request must not re-arm.
            if (r_state == S_ACK) begin
                r_armed <= 1'b0;
            end else if (!cfg_interrupt) begin
                r_armed <= 1'b1;
            end
            if (w_capture) begin
                r_snap.en   <= cfg_msi_enable;
                r_snap.di   <= cfg_interrupt_di;
                r_snap.mme  <= cfg_mmenable;
                r_snap.addr <= cfg_msi_addr;
                r_snap.data <= cfg_msi_data;
                r_snap.cid  <= cfg_completer_id;
            end
            if (r_state == S_DONE && r_snap.en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        w_beat            = 2'd0;
        cfg_interrupt_rdy = 1'b0;
        tx_req            = 1'b0;
        tx_valid          = 1'b0;
        msi_dropped       = 1'b0;
        vec_trunc         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_capture) w_next = S_ACK;
            end
            S_ACK: begin
                cfg_interrupt_rdy = 1'b1;
                vec_trunc         = w_trunc;
                msi_dropped       = !r_snap.en;
                w_next            = r_snap.en ? S_REQ : S_DONE;
            end
            S_REQ: begin
                tx_req = 1'b1;
                if (tx_gnt) w_next = S_BEAT0;
            end
            S_BEAT0: begin
                tx_req   = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready) w_next = S_BEAT1;
            end
            S_BEAT1: begin
                w_beat   = 2'd1;
                tx_req   = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready) w_next = w_last ? S_DONE : S_BEAT2;
            end
            S_BEAT2: begin
                w_beat   = 2'd2;
                tx_req   = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign tx_data      = tx_valid ? w_data : 64'h0;
    assign tx_keep      = tx_valid ? w_keep : 8'h00;
    assign tx_last      = tx_valid && w_last;
    assign busy         = r_state != S_IDLE;
    assign msi_sent_cnt = r_cnt;

endmodule

// File: tb/tb_msi_tlp_gen.sv
// Directed bench for msi_tlp_gen with a beat-level reference model
// and a per-cycle stream monitor.
module tb_msi_tlp_gen;

    localparam int CW = 3;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic          user_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_interrupt = 1'b0;
    logic [7:0]    cfg_interrupt_di = 8'h00;
    logic          cfg_interrupt_rdy;
    logic          cfg_msi_enable = 1'b1;
    logic [2:0]    cfg_mmenable = 3'd0;
    logic [63:0]   cfg_msi_addr = 64'h0;
    logic [15:0]   cfg_msi_data = 16'h0;
    logic [15:0]   cfg_completer_id = 16'h0;
    logic          tx_req;
    logic          tx_gnt = 1'b0;
    logic [63:0]   tx_data;
    logic [7:0]    tx_keep;
    logic          tx_valid;
    logic          tx_last;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          msi_dropped;
    logic          vec_trunc;
    logic [CW-1:0] msi_sent_cnt;

    logic rdy_force = 1'b1;
    logic tog = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int n_rdy = 0, n_drop = 0, n_trunc = 0, n_req = 0;
    int e_rdy = 0, e_drop = 0, e_trunc = 0;
    int exp_cnt = 0;

    beat_t       exp_q[$];
    logic [63:0] got_d[$];
    logic [7:0]  got_k[$];

    msi_tlp_gen #(
        .REQ_TAG (8'h00),
        .CNT_W   (CW)
    ) dut (
        .user_clk          (user_clk),
        .reset_n           (reset_n),
        .cfg_interrupt     (cfg_interrupt),
        .cfg_interrupt_di  (cfg_interrupt_di),
        .cfg_interrupt_rdy (cfg_interrupt_rdy),
        .cfg_msi_enable    (cfg_msi_enable),
        .cfg_mmenable      (cfg_mmenable),
        .cfg_msi_addr      (cfg_msi_addr),
        .cfg_msi_data      (cfg_msi_data),
        .cfg_completer_id  (cfg_completer_id),
        .tx_req            (tx_req),
        .tx_gnt            (tx_gnt),
        .tx_data           (tx_data),
        .tx_keep           (tx_keep),
        .tx_valid          (tx_valid),
        .tx_last           (tx_last),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .msi_dropped       (msi_dropped),
        .vec_trunc         (vec_trunc),
        .msi_sent_cnt      (msi_sent_cnt)
    );

    always #5 user_clk = ~user_clk;

    always @(posedge user_clk) begin
        #1;
        tx_ready = tog ? ~tx_ready : rdy_force;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int span_of(input logic [2:0] mme);
        int m;
        m = (mme > 3'd5) ? 5 : int'(mme);
        return 1 << m;
    endfunction

    // Expected beats from the TLP field rules, written as arithmetic.
    function automatic void model(input logic [63:0] a,
                                  input logic [15:0] md,
                                  input logic [2:0] mme,
                                  input logic [7:0] di,
                                  input logic [15:0] cid);
        int          sp;
        logic [15:0] data;
        logic [31:0] pd, dw1, alo;
        beat_t       b;
        sp   = span_of(mme);
        data = 16'(int'(md) - int'(md) % sp + int'(di) % sp);
        pd   = {data[7:0], data[15:8], 16'h0000};
        dw1  = {cid, 8'h00, 8'h0F};
        alo  = {a[31:2], 2'b00};
        if (a[63:32] == 32'h0) begin
            b = '{{dw1, 32'h4000_0001}, 8'hFF, 1'b0};
            exp_q.push_back(b);
            b = '{{pd, alo}, 8'hFF, 1'b1};
            exp_q.push_back(b);
        end else begin
            b = '{{dw1, 32'h6000_0001}, 8'hFF, 1'b0};
            exp_q.push_back(b);
            b = '{{alo, a[63:32]}, 8'hFF, 1'b0};
            exp_q.push_back(b);
            b = '{{32'h0, pd}, 8'h0F, 1'b1};
            exp_q.push_back(b);
        end
    endfunction

    logic  p_stall = 1'b0;
    beat_t p_beat;

    always @(negedge user_clk) begin
        beat_t e;
        if (cfg_interrupt_rdy) n_rdy++;
        if (msi_dropped) n_drop++;
        if (vec_trunc) n_trunc++;
        if (tx_req) n_req++;
        if (tx_valid) begin
            chk("req_with_valid", 64'(tx_req), 64'd1);
            if (p_stall) begin
                chk("stall_data", tx_data, p_beat.d);
                chk("stall_keep", 64'(tx_keep), 64'(p_beat.k));
                chk("stall_last", 64'(tx_last), 64'(p_beat.l));
            end
            if (tx_ready) begin
                got_d.push_back(tx_data);
                got_k.push_back(tx_keep);
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got %h expected none",
                             tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", tx_data, e.d);
                    chk("beat_keep", 64'(tx_keep), 64'(e.k));
                    chk("beat_last", 64'(tx_last), 64'(e.l));
                end
            end
        end
        p_stall = tx_valid && !tx_ready;
        p_beat  = '{tx_data, tx_keep, tx_last};
    end

    task automatic send_irq(input logic [7:0] di, input int hold);
        logic [63:0] a;
        logic [15:0] md, cid;
        logic [2:0]  mme;
        logic        en;
        bit          seen;
        seen = 0;
        @(posedge user_clk);
        #1;
        cfg_interrupt    = 1'b1;
        cfg_interrupt_di = di;
        a   = cfg_msi_addr;
        md  = cfg_msi_data;
        cid = cfg_completer_id;
        mme = cfg_mmenable;
        en  = cfg_msi_enable;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge user_clk);
            if (cfg_interrupt_rdy) seen = 1;
        end
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL ack_timeout: got no rdy expected rdy");
        end else begin
            e_rdy++;
            chk("no_overlap", 64'(exp_q.size()), 64'd0);
            chk("cnt_at_ack", 64'(msi_sent_cnt), 64'(exp_cnt));
            if (int'(di) >= span_of(mme)) e_trunc++;
            if (en) begin
                model(a, md, mme, di, cid);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end else begin
                e_drop++;
            end
        end
        repeat (hold) @(posedge user_clk);
        @(posedge user_clk);
        #1;
        cfg_interrupt = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge user_clk);
            if (!busy) idle = 1;
        end
        n_chk++;
        if (!idle) begin
            n_err++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        chk("cnt_idle", 64'(msi_sent_cnt), 64'(exp_cnt));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counts(input string nm);
        chk({nm, "_rdy"}, 64'(n_rdy), 64'(e_rdy));
        chk({nm, "_drop"}, 64'(n_drop), 64'(e_drop));
        chk({nm, "_trunc"}, 64'(n_trunc), 64'(e_trunc));
    endtask

    initial begin
        int  r0, q0;
        bit  seen;

        #12;
        chk("reset_outs",
            64'({cfg_interrupt_rdy, tx_req, tx_valid, tx_last, busy,
                 msi_dropped, vec_trunc, tx_keep}), 64'd0);
        chk("reset_data", tx_data, 64'd0);
        chk("reset_cnt", 64'(msi_sent_cnt), 64'd0);
        @(posedge user_clk);
        #1;
        reset_n   = 1'b1;
        tx_gnt    = 1'b1;
        rdy_force = 1'b1;

        // 32-bit address, vector merged into low three bits
        cfg_msi_addr = 64'h0000_0000_FEE0_0000;
        cfg_msi_data = 16'h4020;
        cfg_mmenable = 3'd3;
        got_d.delete();
        got_k.delete();
        send_irq(8'd5, 0);
        wait_idle();
        chk("t1_nbeats", 64'(got_d.size()), 64'd2);
        chk("t1_beat0", got_d[0], 64'h0000_000F_4000_0001);
        chk("t1_beat1", got_d[1], 64'h2540_0000_FEE0_0000);
        chk("t1_cnt", 64'(msi_sent_cnt), 64'd1);
        check_counts("t1");

        // 64-bit address, 4DW header
        cfg_msi_addr     = 64'h0000_0001_0000_1000;
        cfg_mmenable     = 3'd0;
        cfg_completer_id = 16'h0108;
        got_d.delete();
        got_k.delete();
        send_irq(8'd0, 0);
        wait_idle();
        chk("t2_nbeats", 64'(got_d.size()), 64'd3);
        chk("t2_dw0", 64'(got_d[0][31:0]), 64'h6000_0001);
        chk("t2_dw1", 64'(got_d[0][63:32]), 64'h0108_000F);
        chk("t2_beat1", got_d[1], 64'h0000_1000_0000_0001);
        chk("t2_keep2", 64'(got_k[2]), 64'h0F);
        cfg_completer_id = 16'h0000;

        // vector wider than the allocation
        cfg_msi_addr = 64'h0000_0000_FEE0_0000;
        cfg_msi_data = 16'hABCD;
        cfg_mmenable = 3'd1;
        got_d.delete();
        got_k.delete();
        send_irq(8'd6, 0);
        wait_idle();
        chk("t3_pd", 64'(got_d[1][63:32]), 64'hCCAB_0000);
        check_counts("t3");

        // MSI disabled, request level held
        cfg_msi_enable = 1'b0;
        cfg_mmenable   = 3'd0;
        r0 = n_rdy;
        q0 = n_req;
        send_irq(8'd0, 10);
        wait_idle();
        repeat (3) @(negedge user_clk);
        chk("t4_one_rdy", 64'(n_rdy - r0), 64'd1);
        chk("t4_no_req", 64'(n_req - q0), 64'd0);
        chk("t4_cnt", 64'(msi_sent_cnt), 64'd3);
        check_counts("t4");
        cfg_msi_enable = 1'b1;

        // backpressure, second request raised mid-TLP
        cfg_mmenable = 3'd3;
        cfg_msi_data = 16'h4020;
        tog = 1'b1;
        send_irq(8'd3, 0);
        send_irq(8'd4, 0);
        wait_idle();
        chk("t5_cnt", 64'(msi_sent_cnt), 64'd5);

        // snapshot is committed once captured
        cfg_msi_addr = 64'h0000_0003_0000_0200;
        send_irq(8'd2, 0);
        cfg_msi_addr   = 64'h0000_0000_1234_0000;
        cfg_msi_enable = 1'b0;
        wait_idle();
        cfg_msi_enable = 1'b1;
        tog = 1'b0;
        rdy_force = 1'b1;

        // grant withheld
        tx_gnt = 1'b0;
        send_irq(8'd1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge user_clk);
            chk("nognt_req", 64'(tx_req), 64'd1);
            chk("nognt_valid", 64'(tx_valid), 64'd0);
        end
        tx_gnt = 1'b1;
        wait_idle();

        // counter wrap
        send_irq(8'd0, 0);
        wait_idle();
        send_irq(8'd7, 0);
        wait_idle();
        chk("wrap_cnt", 64'(msi_sent_cnt), 64'd1);
        check_counts("t8");

        // reset in the middle of a 4DW TLP
        rdy_force = 1'b0;
        cfg_msi_addr = 64'h0000_0002_0000_0040;
        send_irq(8'd1, 0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge user_clk);
            seen = tx_valid;
        end
        chk("rst_b0_valid", 64'(seen), 64'd1);
        rdy_force = 1'b1;
        @(negedge user_clk);
        rdy_force = 1'b0;
        @(posedge user_clk);
        #3;
        chk("rst_b1_valid", 64'(tx_valid), 64'd1);
        chk("rst_b1_data", tx_data, 64'h0000_0040_0000_0002);
        reset_n = 1'b0;
        #1;
        chk("rst_valid_async", 64'(tx_valid), 64'd0);
        chk("rst_req_async", 64'(tx_req), 64'd0);
        chk("rst_cnt", 64'(msi_sent_cnt), 64'd0);
        exp_q.delete();
        exp_cnt = 0;
        repeat (2) @(posedge user_clk);
        #1;
        reset_n   = 1'b1;
        rdy_force = 1'b1;
        cfg_msi_addr = 64'h0000_0000_FEE0_1000;
        got_d.delete();
        got_k.delete();
        send_irq(8'd2, 0);
        wait_idle();
        chk("post_rst_nbeats", 64'(got_d.size()), 64'd2);
        chk("post_rst_cnt", 64'(msi_sent_cnt), 64'd1);
        check_counts("end");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
